// File: rtl/nios_system_vga_cpu_mult_seq.sv
// rtl/nios_system_vga_cpu_mult_seq.sv - sequencer turning a 3-partial-product 16x16 cell into a 32x32 unsigned multiplier
//
// Ports:
//   clk, reset_n           clock, asynchronous active-low reset
//   flush                  synchronous abort of any in-flight operation
//   req_valid/req_ready    request handshake; req_op 0 = MUL (low word), 1 = MULXUU (high word)
//   req_a, req_b           unsigned 32-bit operands
//   rsp_valid/rsp_ready    response handshake; rsp_data holds the result word
//   busy                   high whenever the sequencer is not idle
//   cell_src1/cell_src2    operands driven to the multiplier cell
//   cell_en                multiplier cell clock enable
//   cell_p1..cell_p3       cell partial products (lo*lo, lo(src1)*hi(src2), hi(src1)*lo(src2))

module nios_system_vga_cpu_mult_seq #(
  parameter int CELL_LAT = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        flush,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        busy,
  output logic [31:0] cell_src1,
  output logic [31:0] cell_src2,
  output logic        cell_en,
  input  logic [31:0] cell_p1,
  input  logic [31:0] cell_p2,
  input  logic [31:0] cell_p3
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ISSUE1 = 3'd1,
    CAP1   = 3'd2,
    ISSUE2 = 3'd3,
    CAP2   = 3'd4,
    DONE   = 3'd5
  } state_t;

  // Counter runs CELL_LAT-1 down to 0, so each ISSUE state lasts CELL_LAT cycles.
  localparam logic [1:0] LAT_M1 = 2'(CELL_LAT - 1);

  state_t      state;
  logic [1:0]  wait_cnt;
  logic        op_r;
  logic [15:0] a_hi;
  logic [15:0] b_hi;
  logic        carry;
  logic [16:0] mid_hi;

  logic [32:0] mid;
  logic [32:0] lo;
  logic [31:0] hi_sum;

  always_comb begin
    mid    = {1'b0, cell_p2} + {1'b0, cell_p3};
    lo     = {1'b0, cell_p1} + {1'b0, mid[15:0], 16'h0000};
    // Upper word: a_hi*b_hi plus the cross-term bits above 2^32 and the low-word carry.
    hi_sum = cell_p1 + {15'h0000, mid_hi} + {31'h0, carry};
  end

  // Handshake and enable outputs are pure decodes of the state register.
  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign rsp_valid = (state == DONE);
  assign cell_en   = (state == ISSUE1) || (state == ISSUE2);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      wait_cnt  <= 2'd0;
      op_r      <= 1'b0;
      a_hi      <= 16'h0000;
      b_hi      <= 16'h0000;
      carry     <= 1'b0;
      mid_hi    <= 17'h00000;
      rsp_data  <= 32'h0000_0000;
      cell_src1 <= 32'h0000_0000;
      cell_src2 <= 32'h0000_0000;
    end else if (flush) begin
      state    <= IDLE;
      wait_cnt <= 2'd0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            op_r      <= req_op;
            a_hi      <= req_a[31:16];
            b_hi      <= req_b[31:16];
            cell_src1 <= req_a;
            cell_src2 <= req_b;
            wait_cnt  <= LAT_M1;
            state     <= ISSUE1;
          end
        end
        ISSUE1: begin
          if (wait_cnt == 2'd0) state <= CAP1;
          else                  wait_cnt <= wait_cnt - 2'd1;
        end
        CAP1: begin
          carry  <= lo[32];
          mid_hi <= mid[32:16];
          if (!op_r) begin
            rsp_data <= lo[31:0];
            state    <= DONE;
          end else begin
            // Second pass reuses p1 to form a_hi*b_hi.
            cell_src1 <= {16'h0000, a_hi};
            cell_src2 <= {16'h0000, b_hi};
            wait_cnt  <= LAT_M1;
            state     <= ISSUE2;
          end
        end
        ISSUE2: begin
          if (wait_cnt == 2'd0) state <= CAP2;
          else                  wait_cnt <= wait_cnt - 2'd1;
        end
        CAP2: begin
          rsp_data <= hi_sum;
          state    <= DONE;
        end
        DONE: begin
          if (rsp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nios_system_vga_cpu_mult_seq.sv
// tb/tb_nios_system_vga_cpu_mult_seq.sv - scoreboard bench for the 32x32 multiply sequencer

module tb_nios_system_vga_cpu_mult_seq;

  typedef struct {
    logic [31:0] data;
    int          lat;
    int          acc;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Instance 0: CELL_LAT = 1
  logic        flush0 = 1'b0, req_valid0 = 1'b0, req_op0 = 1'b0, rsp_ready0 = 1'b1;
  logic [31:0] req_a0 = '0, req_b0 = '0;
  logic        req_ready0, rsp_valid0, busy0, cell_en0;
  logic [31:0] rsp_data0, src1_0, src2_0;
  logic [31:0] p1_0 = '0, p2_0 = '0, p3_0 = '0;

  // Instance 1: CELL_LAT = 2
  logic        req_valid1 = 1'b0, req_op1 = 1'b0;
  logic [31:0] req_a1 = '0, req_b1 = '0;
  logic        req_ready1, rsp_valid1, busy1, cell_en1;
  logic [31:0] rsp_data1, src1_1, src2_1;
  logic [31:0] p1_1 = '0, p2_1 = '0, p3_1 = '0;

  nios_system_vga_cpu_mult_seq #(.CELL_LAT(1)) u0 (
    .clk(clk), .reset_n(reset_n), .flush(flush0),
    .req_valid(req_valid0), .req_ready(req_ready0), .req_op(req_op0),
    .req_a(req_a0), .req_b(req_b0),
    .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready0), .rsp_data(rsp_data0),
    .busy(busy0), .cell_src1(src1_0), .cell_src2(src2_0), .cell_en(cell_en0),
    .cell_p1(p1_0), .cell_p2(p2_0), .cell_p3(p3_0)
  );

  nios_system_vga_cpu_mult_seq #(.CELL_LAT(2)) u1 (
    .clk(clk), .reset_n(reset_n), .flush(1'b0),
    .req_valid(req_valid1), .req_ready(req_ready1), .req_op(req_op1),
    .req_a(req_a1), .req_b(req_b1),
    .rsp_valid(rsp_valid1), .rsp_ready(1'b1), .rsp_data(rsp_data1),
    .busy(busy1), .cell_src1(src1_1), .cell_src2(src2_1), .cell_en(cell_en1),
    .cell_p1(p1_1), .cell_p2(p2_1), .cell_p3(p3_1)
  );

  // Multiplier cell models: products update on edges where the enable is high.
  always @(posedge clk) begin
    if (cell_en0) begin
      p1_0 <= 32'(src1_0[15:0]) * 32'(src2_0[15:0]);
      p2_0 <= 32'(src1_0[15:0]) * 32'(src2_0[31:16]);
      p3_0 <= 32'(src1_0[31:16]) * 32'(src2_0[15:0]);
    end
    if (cell_en1) begin
      p1_1 <= 32'(src1_1[15:0]) * 32'(src2_1[15:0]);
      p2_1 <= 32'(src1_1[15:0]) * 32'(src2_1[31:16]);
      p3_1 <= 32'(src1_1[31:16]) * 32'(src2_1[15:0]);
    end
  end

  int en_cnt0 = 0, en_cnt1 = 0;
  always @(posedge clk) begin
    if (cell_en0) en_cnt0 <= en_cnt0 + 1;
    if (cell_en1) en_cnt1 <= en_cnt1 + 1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  exp_t q0[$];
  exp_t q1[$];
  logic pv0 = 1'b0, pv1 = 1'b0;

  // Monitors: check latency and data on the first valid cycle, data again at handshake, then pop.
  always @(negedge clk) begin
    if (!reset_n) begin
      pv0 <= 1'b0;
    end else begin
      if (rsp_valid0 && !pv0) begin
        if (q0.size() == 0) chk("u0_unexpected_rsp", 64'(rsp_data0), 64'hDEAD);
        else begin
          chk("u0_latency", 64'(cyc - q0[0].acc), 64'(q0[0].lat));
          chk("u0_data_first", 64'(rsp_data0), 64'(q0[0].data));
        end
      end
      if (rsp_valid0 && rsp_ready0 && q0.size() != 0) begin
        chk("u0_data_hs", 64'(rsp_data0), 64'(q0[0].data));
        void'(q0.pop_front());
      end
      pv0 <= rsp_valid0;
    end
  end

  always @(negedge clk) begin
    if (!reset_n) begin
      pv1 <= 1'b0;
    end else begin
      if (rsp_valid1 && !pv1) begin
        if (q1.size() == 0) chk("u1_unexpected_rsp", 64'(rsp_data1), 64'hDEAD);
        else begin
          chk("u1_latency", 64'(cyc - q1[0].acc), 64'(q1[0].lat));
          chk("u1_data", 64'(rsp_data1), 64'(q1[0].data));
          void'(q1.pop_front());
        end
      end
      pv1 <= rsp_valid1;
    end
  end

  // Issue one request to u0; returns at #1 after the accept edge.
  task automatic issue0(input logic op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input bit push);
    int n;
    exp_t e;
    @(negedge clk);
    req_valid0 = 1'b1; req_op0 = op; req_a0 = a; req_b0 = b;
    n = 0;
    while (!req_ready0 && n < 50) begin @(negedge clk); n++; end
    if (!req_ready0) chk("u0_accept_timeout", 64'(req_ready0), 64'd1);
    en_cnt0 = 0;
    e.data = exp; e.lat = op ? 5 : 3; e.acc = cyc;
    if (push) q0.push_back(e);
    @(posedge clk); #1;
    req_valid0 = 1'b0;
  endtask

  task automatic wait_idle0();
    int n;
    n = 0;
    @(negedge clk);
    while ((busy0 || q0.size() != 0) && n < 100) begin @(negedge clk); n++; end
    if (busy0) chk("u0_idle_timeout", 64'(busy0), 64'd0);
  endtask

  typedef struct {
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int n;
    exp_t e;
    vecs.push_back('{1'b0, 32'h0000_0003, 32'h0000_0005, 32'h0000_000F});
    vecs.push_back('{1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE});
    vecs.push_back('{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001});
    vecs.push_back('{1'b0, 32'h0001_FFFF, 32'h0001_FFFF, 32'hFFFC_0001});
    vecs.push_back('{1'b1, 32'h0001_FFFF, 32'h0001_FFFF, 32'h0000_0003});
    vecs.push_back('{1'b1, 32'h8000_0000, 32'h0000_0004, 32'h0000_0002});
    vecs.push_back('{1'b0, 32'h8000_0000, 32'h0000_0004, 32'h0000_0000});

    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    chk("reset_state", {rsp_data0, src1_0[7:0], src2_0[7:0], req_ready0, rsp_valid0, busy0, cell_en0},
        {32'h0, 8'h0, 8'h0, 1'b1, 1'b0, 1'b0, 1'b0});

    // Directed vectors with rsp_ready held high.
    foreach (vecs[i]) begin
      issue0(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, 1'b1);
      wait_idle0();
      if (i == 0) chk("u0_cell_en_cycles", 64'(en_cnt0), 64'd1);
    end

    // Backpressure: hold DONE for 10 cycles.
    rsp_ready0 = 1'b0;
    issue0(1'b0, 32'h0000_0003, 32'h0000_0005, 32'h0000_000F, 1'b1);
    n = 0;
    @(negedge clk);
    while (!rsp_valid0 && n < 20) begin @(negedge clk); n++; end
    chk("bp_reach_done", 64'(rsp_valid0), 64'd1);
    for (int k = 0; k < 10; k++) begin
      chk("bp_hold", {rsp_data0, rsp_valid0, req_ready0, cell_en0}, {32'h0000_000F, 1'b1, 1'b0, 1'b0});
      @(negedge clk);
    end
    @(posedge clk); #1 rsp_ready0 = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_release", {req_ready0, rsp_valid0}, {1'b1, 1'b0});

    // Flush during ISSUE2 of a MULXUU.
    issue0(1'b1, 32'hABCD_1234, 32'h5678_9ABC, 32'h0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("flush_in_issue2", {cell_en0, src1_0}, {1'b1, 32'h0000_ABCD});
    flush0 = 1'b1;
    @(posedge clk); #1;
    flush0 = 1'b0;
    chk("flush_to_idle", {busy0, req_ready0, rsp_valid0, cell_en0}, {1'b0, 1'b1, 1'b0, 1'b0});
    repeat (8) @(negedge clk);

    // Flush wins over a simultaneous request in IDLE.
    @(negedge clk);
    flush0 = 1'b1; req_valid0 = 1'b1; req_op0 = 1'b0; req_a0 = 32'd7; req_b0 = 32'd7;
    @(posedge clk); #1;
    flush0 = 1'b0; req_valid0 = 1'b0;
    chk("flush_prio", {busy0, req_ready0}, {1'b0, 1'b1});
    repeat (6) @(negedge clk);

    // Reset pulse during CAP1.
    issue0(1'b0, 32'h0000_1111, 32'h0000_2222, 32'h0, 1'b0);
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    chk("reset_mid_op", {rsp_data0, src1_0, src2_0, req_ready0, rsp_valid0, busy0, cell_en0},
        {32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0});
    @(posedge clk); #1 reset_n = 1'b1;
    issue0(1'b0, 32'h0000_1111, 32'h0000_2222, 32'h0246_8642, 1'b1);
    wait_idle0();

    // CELL_LAT = 2 instance.
    @(negedge clk);
    req_valid1 = 1'b1; req_op1 = 1'b0; req_a1 = 32'h1234_5678; req_b1 = 32'h0001_0000;
    en_cnt1 = 0;
    e.data = 32'h5678_0000; e.lat = 4; e.acc = cyc;
    q1.push_back(e);
    @(posedge clk); #1 req_valid1 = 1'b0;
    n = 0;
    while (q1.size() != 0 && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    chk("u1_cell_en_cycles", 64'(en_cnt1), 64'd2);
    chk("u1_idle", {busy1, req_ready1}, {1'b0, 1'b1});

    chk("u0_queue_drained", 64'(q0.size()), 64'd0);
    chk("u1_queue_drained", 64'(q1.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
